dm_cache_ctrl: RTL

Parametrised, synthesizable direct-mapped write-back cache controller between the pipeline load/store stage and the block-wide RAM. It adds dirty tracking, write-allocate, a valid/ready CPU handshake, a valid/ready memory handshake, misalignment error reporting and a full-cache flush. It is driven entirely by a clocked FSM; it contains no wait statements and no combinational state updates.

---
 rtl/cache_pkg.sv | 57 +++++
 rtl/cache_line_array.sv | 78 +++++++
 rtl/dm_cache_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped cache controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL_REQ,
        REFILL_WAIT,
        RESPOND,
        FLUSH_SCAN,
        FLUSH_WB
    } cache_state_t;

    // Widest byte address the helpers handle; callers zero-extend into it.
    localparam int ADDR_MAX_W = 64;
    typedef logic [ADDR_MAX_W-1:0] addr_max_t;

    // Byte-offset-within-line width.
    function automatic int calc_off_w(int data_w, int words_per_block);
        return $clog2(words_per_block * data_w / 8);
    endfunction

    function automatic int calc_idx_w(int num_rows);
        return $clog2(num_rows);
    endfunction

    function automatic int calc_tag_w(int addr_w, int data_w, int words_per_block, int num_rows);
        return addr_w - calc_off_w(data_w, words_per_block) - calc_idx_w(num_rows);
    endfunction

    // Word-select width; kept at least 1 so single-word lines still get a legal port.
    function automatic int calc_wsel_w(int words_per_block);
        return (words_per_block > 1) ? $clog2(words_per_block) : 1;
    endfunction

    function automatic addr_max_t addr_index(addr_max_t addr, int off_w, int idx_w);
        return (addr >> off_w) & ((addr_max_t'(1) << idx_w) - addr_max_t'(1));
    endfunction

    function automatic addr_max_t addr_tag(addr_max_t addr, int off_w, int idx_w);
        return addr >> (off_w + idx_w);
    endfunction

    // Word number within the line, from the bits above the byte-in-word offset.
    function automatic addr_max_t word_sel(addr_max_t addr, int data_w, int words_per_block);
        return (addr >> $clog2(data_w / 8)) & addr_max_t'(words_per_block - 1);
    endfunction

    // Any nonzero byte-in-word offset is an unaligned word access.
    function automatic logic is_misaligned(addr_max_t addr, int data_w);
        return (addr & addr_max_t'(data_w / 8 - 1)) != '0;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Register file of cache lines: valid, dirty, tag and data per row.
// Latency: reads are combinational by index; writes, merges and clear land on the next edge.
// Backpressure: none; every write port is accepted unconditionally.
module cache_line_array #(
    parameter int NUM_ROWS        = 8,
    parameter int IDX_W           = 3,
    parameter int TAG_W           = 11,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 2,
    parameter int WSEL_W          = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // read port
    input  logic [IDX_W-1:0]                  rd_idx,
    output logic                              rd_valid,
    output logic                              rd_dirty,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic [DATA_W*WORDS_PER_BLOCK-1:0] rd_data,
    // whole-line install (marks the row valid)
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [TAG_W-1:0]                  wr_tag,
    input  logic                              wr_dirty,
    input  logic [DATA_W*WORDS_PER_BLOCK-1:0] wr_data,
    // single-word merge (marks the row dirty)
    input  logic                              mrg_en,
    input  logic [IDX_W-1:0]                  mrg_idx,
    input  logic [WSEL_W-1:0]                 mrg_word,
    input  logic [DATA_W-1:0]                 mrg_data,
    // invalidate everything
    input  logic                              clear_all
);

    logic [NUM_ROWS-1:0]               valid_q;
    logic [NUM_ROWS-1:0]               dirty_q;
    logic [TAG_W-1:0]                  tag_q  [NUM_ROWS];
    logic [DATA_W*WORDS_PER_BLOCK-1:0] data_q [NUM_ROWS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    // Row status and tags; a merge after an install in the same edge leaves the row dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                tag_q[i] <= '0;
            end
        end else if (clear_all) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[wr_idx] <= 1'b1;
                dirty_q[wr_idx] <= wr_dirty;
                tag_q[wr_idx]   <= wr_tag;
            end
            if (mrg_en) begin
                dirty_q[mrg_idx] <= 1'b1;
            end
        end
    end

    // Line payload; the word merge is ordered after the install so a write-allocate store wins.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx] <= wr_data;
        end
        if (mrg_en) begin
            data_q[mrg_idx][mrg_word*DATA_W +: DATA_W] <= mrg_data;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller with full-cache flush.
// Latency: hit responds 2 cycles after acceptance; miss adds write-back and refill handshakes.
// Backpressure: cpu_req_ready only in IDLE without flush; memory requests held stable until mem_req_ready.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int NUM_ROWS        = 8,
    parameter int WORDS_PER_BLOCK = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cpu_req_valid,
    output logic                              cpu_req_ready,
    input  logic                              cpu_req_we,
    input  logic [ADDR_W-1:0]                 cpu_req_addr,
    input  logic [DATA_W-1:0]                 cpu_req_wdata,
    output logic                              cpu_resp_valid,
    output logic [DATA_W-1:0]                 cpu_resp_rdata,
    output logic                              cpu_resp_err,
    input  logic                              flush_req,
    output logic                              flush_done,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic                              mem_req_we,
    output logic [ADDR_W-1:0]                 mem_req_addr,
    output logic [DATA_W*WORDS_PER_BLOCK-1:0] mem_req_wdata,
    input  logic                              mem_resp_valid,
    input  logic [DATA_W*WORDS_PER_BLOCK-1:0] mem_resp_rdata
);

    localparam int OFF_W  = calc_off_w(DATA_W, WORDS_PER_BLOCK);
    localparam int IDX_W  = calc_idx_w(NUM_ROWS);
    localparam int TAG_W  = calc_tag_w(ADDR_W, DATA_W, WORDS_PER_BLOCK, NUM_ROWS);
    localparam int WSEL_W = calc_wsel_w(WORDS_PER_BLOCK);
    localparam int BLK_W  = DATA_W * WORDS_PER_BLOCK;
    // Scan counter runs one past the last row; that extra step is the done cycle.
    localparam logic [IDX_W:0] SCAN_END = (IDX_W+1)'(NUM_ROWS);

    cache_state_t state_q, state_d;

    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [IDX_W:0]    flush_idx_q;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_word;
    logic              req_mis;
    logic              in_flush;
    logic [IDX_W-1:0]  arr_idx;

    logic              rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [BLK_W-1:0]  rd_data;
    logic [DATA_W-1:0] rd_word;
    logic              hit;
    logic              wr_en, mrg_en, clear_all;

    assign req_idx  = IDX_W'(addr_index(addr_max_t'(req_addr_q), OFF_W, IDX_W));
    assign req_tag  = TAG_W'(addr_tag(addr_max_t'(req_addr_q), OFF_W, IDX_W));
    assign req_word = WSEL_W'(word_sel(addr_max_t'(req_addr_q), DATA_W, WORDS_PER_BLOCK));
    assign req_mis  = is_misaligned(addr_max_t'(req_addr_q), DATA_W);

    assign in_flush = (state_q == FLUSH_SCAN) || (state_q == FLUSH_WB);
    assign arr_idx  = in_flush ? flush_idx_q[IDX_W-1:0] : req_idx;
    assign rd_word  = rd_data[req_word*DATA_W +: DATA_W];
    assign hit      = rd_valid && (rd_tag == req_tag);

    cache_line_array #(
        .NUM_ROWS        (NUM_ROWS),
        .IDX_W           (IDX_W),
        .TAG_W           (TAG_W),
        .DATA_W          (DATA_W),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .WSEL_W          (WSEL_W)
    ) u_lines (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (arr_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (req_idx),
        .wr_tag    (req_tag),
        .wr_dirty  (req_we_q),
        .wr_data   (mem_resp_rdata),
        .mrg_en    (mrg_en),
        .mrg_idx   (req_idx),
        .mrg_word  (req_word),
        .mrg_data  (req_wdata_q),
        .clear_all (clear_all)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture on acceptance and the flush row counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            flush_idx_q <= '0;
        end else begin
            if (state_q == IDLE && cpu_req_valid && cpu_req_ready) begin
                req_we_q    <= cpu_req_we;
                req_addr_q  <= cpu_req_addr;
                req_wdata_q <= cpu_req_wdata;
            end
            if (state_q == IDLE) begin
                flush_idx_q <= '0;
            end else if (state_q == FLUSH_SCAN && flush_idx_q != SCAN_END && !(rd_valid && rd_dirty)) begin
                flush_idx_q <= flush_idx_q + (IDX_W+1)'(1);
            end else if (state_q == FLUSH_WB && mem_req_ready) begin
                flush_idx_q <= flush_idx_q + (IDX_W+1)'(1);
            end
        end
    end

    // Next-state and all handshake outputs, decoded from the current state.
    always_comb begin
        state_d        = state_q;
        wr_en          = 1'b0;
        mrg_en         = 1'b0;
        clear_all      = 1'b0;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        cpu_resp_err   = 1'b0;
        flush_done     = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        case (state_q)
            IDLE: begin
                cpu_req_ready = rst_n && !flush_req;
                if (flush_req) begin
                    state_d = FLUSH_SCAN;
                end else if (cpu_req_valid) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (req_mis) begin
                    state_d = RESPOND;
                end else if (hit) begin
                    mrg_en  = req_we_q;
                    state_d = RESPOND;
                end else if (rd_valid && rd_dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = REFILL_REQ;
                end
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {rd_tag, req_idx, {OFF_W{1'b0}}};
                mem_req_wdata = rd_data;
                if (mem_req_ready) begin
                    state_d = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (mem_req_ready) begin
                    state_d = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    wr_en   = 1'b1;
                    mrg_en  = req_we_q;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_err   = req_mis;
                cpu_resp_rdata = (req_we_q || req_mis) ? '0 : rd_word;
                state_d        = IDLE;
            end
            FLUSH_SCAN: begin
                if (flush_idx_q == SCAN_END) begin
                    clear_all  = 1'b1;
                    flush_done = 1'b1;
                    state_d    = IDLE;
                end else if (rd_valid && rd_dirty) begin
                    state_d = FLUSH_WB;
                end
            end
            FLUSH_WB: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {rd_tag, flush_idx_q[IDX_W-1:0], {OFF_W{1'b0}}};
                mem_req_wdata = rd_data;
                if (mem_req_ready) begin
                    state_d = FLUSH_SCAN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
